// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads the icache and feeds the IF/ID latch,
// with a one-entry hold buffer for stalls plus redirect and halt handling.
module fetch_unit #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic [31:0] imemload,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic [31:0] imemaddr_if,
    output logic [31:0] imemload_if,
    output logic        fetch_valid
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        HOLD   = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t      state;
    // Only the word index is stored, so pc[1:0] is structurally 00 and +4 wraps mod 2^32.
    logic [29:0] pc_word;
    logic [31:0] hold_addr;
    logic [31:0] hold_instr;

    assign imemaddr = {pc_word, 2'b00};
    assign imemREN  = (state == FETCH);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state       <= FETCH;
            pc_word     <= PC_INIT[31:2];
            hold_addr   <= '0;
            hold_instr  <= '0;
            imemaddr_if <= '0;
            imemload_if <= '0;
            fetch_valid <= 1'b0;
        end else if (halt || state == HALTED) begin
            state       <= HALTED;
            fetch_valid <= 1'b0;
        end else if (redirect) begin
            // Leaving HOLD abandons the buffered wrong-path instruction.
            pc_word     <= redirect_pc[31:2];
            state       <= FETCH;
            fetch_valid <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (ihit) begin
                        pc_word <= pc_word + 30'd1;
                        if (stall) begin
                            hold_addr  <= imemaddr;
                            hold_instr <= imemload;
                            state      <= HOLD;
                        end else begin
                            imemaddr_if <= imemaddr;
                            imemload_if <= imemload;
                            fetch_valid <= 1'b1;
                        end
                    end else if (!stall) begin
                        fetch_valid <= 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        imemaddr_if <= hold_addr;
                        imemload_if <= hold_instr;
                        fetch_valid <= 1'b1;
                        state       <= FETCH;
                    end
                end
                default: begin
                    state <= HALTED;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, reset corners and randomized run
// against a queue-based behavioural model.
module tb_fetch_unit;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        ihit;
    logic [31:0] imemload;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt;
    logic [31:0] imemaddr_if;
    logic [31:0] imemload_if;
    logic        fetch_valid;

    fetch_unit #(.PC_INIT(32'h0000_0000)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .imemload(imemload),
        .imemREN(imemREN), .imemaddr(imemaddr), .stall(stall),
        .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
        .imemaddr_if(imemaddr_if), .imemload_if(imemload_if),
        .fetch_valid(fetch_valid)
    );

    always #5 CLK = ~CLK;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
    } entry_t;

    // Behavioural model: an instruction pending in the IF/ID side buffer is a queue entry.
    logic [31:0] m_pc;
    logic        m_halted;
    entry_t      m_buf[$];
    logic [31:0] m_aif, m_lif;
    logic        m_v;

    function automatic logic [31:0] instr_at(input logic [31:0] a);
        return 32'h1000_0000 + a;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_halted = 1'b0; m_buf.delete();
        m_aif = '0; m_lif = '0; m_v = 1'b0;
    endtask

    task automatic model_clock();
        entry_t e;
        if (m_halted || halt) begin
            m_halted = 1'b1;
            m_v = 1'b0;
        end else if (redirect) begin
            m_pc = redirect_pc & 32'hFFFF_FFFC;
            m_buf.delete();
            m_v = 1'b0;
        end else if (m_buf.size() != 0) begin
            if (!stall) begin
                e = m_buf.pop_front();
                m_aif = e.addr; m_lif = e.instr; m_v = 1'b1;
            end
        end else if (ihit) begin
            if (stall) begin
                e.addr = m_pc; e.instr = imemload;
                m_buf.push_back(e);
            end else begin
                m_aif = m_pc; m_lif = imemload; m_v = 1'b1;
            end
            m_pc = m_pc + 32'd4;
        end else if (!stall) begin
            m_v = 1'b0;
        end
    endtask

    task automatic check_regs();
        check("imemaddr_if", imemaddr_if, m_aif);
        check("imemload_if", imemload_if, m_lif);
        check("fetch_valid", {31'b0, fetch_valid}, {31'b0, m_v});
    endtask

    // Called at a negedge; returns the request seen before the clock edge.
    task automatic step(input logic ih, input logic st, input logic rd,
                        input logic [31:0] rpc, input logic ht,
                        output logic [31:0] obs_addr, output logic obs_ren);
        ihit = ih; stall = st; redirect = rd; redirect_pc = rpc; halt = ht;
        imemload = ih ? instr_at(m_pc) : $urandom;
        #1;
        obs_addr = imemaddr;
        obs_ren  = imemREN;
        check("imemaddr", imemaddr, m_pc);
        check("imemREN", {31'b0, imemREN}, {31'b0, !m_halted && m_buf.size() == 0});
        @(posedge CLK);
        model_clock();
        @(negedge CLK);
        check_regs();
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        #1;
        model_reset();
        check("rst_imemaddr", imemaddr, 32'h0);
        check("rst_imemREN", {31'b0, imemREN}, 32'd1);
        check("rst_valid", {31'b0, fetch_valid}, 32'd0);
        check("rst_addr_if", imemaddr_if, 32'h0);
        check("rst_load_if", imemload_if, 32'h0);
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    typedef struct {
        logic        ih, st, rd;
        logic [31:0] rpc;
        logic        ht;
        logic [31:0] ea;
        logic        er;
        logic        ev;
        logic [31:0] eaif;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic ih, input logic st, input logic rd, input logic [31:0] rpc,
                       input logic ht, input logic [31:0] ea, input logic er,
                       input logic ev, input logic [31:0] eaif);
        vec_t v;
        v.ih = ih; v.st = st; v.rd = rd; v.rpc = rpc; v.ht = ht;
        v.ea = ea; v.er = er; v.ev = ev; v.eaif = eaif;
        tbl.push_back(v);
    endtask

    initial begin
        logic [31:0] oa;
        logic        orr;
        int          halted_cycles;

        nRST = 1'b0; ihit = 1'b0; stall = 1'b0; redirect = 1'b0;
        redirect_pc = '0; halt = 1'b0; imemload = '0;
        model_reset();

        //   ih    st    rd    rpc            ht    imemaddr       ren   valid addr_if
        add(1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 1'b1, 32'h0);
        add(1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h4,        1'b1, 1'b1, 32'h4);
        add(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h8,        1'b1, 1'b0, 32'h4);
        add(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h8,        1'b1, 1'b0, 32'h4);
        add(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h8,        1'b1, 1'b0, 32'h4);
        add(1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h8,        1'b1, 1'b1, 32'h8);
        add(1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'hC,        1'b1, 1'b1, 32'h8);
        add(1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h10,       1'b0, 1'b1, 32'h8);
        add(1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h10,       1'b0, 1'b1, 32'h8);
        add(1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h10,       1'b0, 1'b1, 32'h8);
        add(1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h10,       1'b0, 1'b1, 32'hC);
        add(1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h10,       1'b1, 1'b1, 32'h10);
        add(1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h14,       1'b1, 1'b1, 32'h10);
        add(1'b1, 1'b0, 1'b1, 32'h103,      1'b0, 32'h18,       1'b0, 1'b0, 32'h10);
        add(1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h100,      1'b1, 1'b1, 32'h100);
        add(1'b1, 1'b1, 1'b1, 32'h200,      1'b0, 32'h104,      1'b1, 1'b0, 32'h100);
        add(1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h200,      1'b1, 1'b1, 32'h200);
        add(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h204,     1'b1, 1'b0, 32'h200);
        add(1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'hFFFF_FFFC, 1'b1, 1'b1, 32'hFFFF_FFFC);
        add(1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 1'b1, 32'h0);
        add(1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h4,        1'b1, 1'b0, 32'h0);
        add(1'b1, 1'b0, 1'b1, 32'h300,      1'b0, 32'h4,        1'b0, 1'b0, 32'h0);
        add(1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h4,        1'b0, 1'b0, 32'h0);

        @(negedge CLK);
        do_reset();

        foreach (tbl[i]) begin
            step(tbl[i].ih, tbl[i].st, tbl[i].rd, tbl[i].rpc, tbl[i].ht, oa, orr);
            check($sformatf("tbl%0d_imemaddr", i), oa, tbl[i].ea);
            check($sformatf("tbl%0d_imemREN", i), {31'b0, orr}, {31'b0, tbl[i].er});
            check($sformatf("tbl%0d_valid", i), {31'b0, fetch_valid}, {31'b0, tbl[i].ev});
            check($sformatf("tbl%0d_addr_if", i), imemaddr_if, tbl[i].eaif);
            if (tbl[i].ev)
                check($sformatf("tbl%0d_load_if", i), imemload_if, instr_at(tbl[i].eaif));
        end

        // Halt recovery: only reset restores PC_INIT.
        do_reset();
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, oa, orr);
        check("post_halt_pc", oa, 32'h0);

        // Asynchronous reset while parked in HOLD with a pending instruction.
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, oa, orr);
        #2;
        nRST = 1'b0;
        #1;
        model_reset();
        check("async_imemaddr", imemaddr, 32'h0);
        check("async_imemREN", {31'b0, imemREN}, 32'd1);
        check("async_valid", {31'b0, fetch_valid}, 32'd0);
        check("async_addr_if", imemaddr_if, 32'h0);
        @(negedge CLK);
        nRST = 1'b1;

        halted_cycles = 0;
        for (int c = 0; c < 3000; c++) begin
            if (m_halted) halted_cycles++;
            if (halted_cycles > 8) begin
                halted_cycles = 0;
                do_reset();
            end else begin
                step($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 3,
                     $urandom_range(0, 19) == 0, $urandom, $urandom_range(0, 199) == 0,
                     oa, orr);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
